// File: rtl/zoom_nn_ud_if.sv
// rtl/zoom_nn_ud_if.sv - handshake, ROM read and frame-RAM write signals of the resampler
interface zoom_nn_ud_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19
);
  logic              start;
  logic              modo;
  logic [2:0]        fator;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [ADDR_W-1:0] ram_wraddr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic              busy;
  logic              done;
  logic              erro;

  modport master (
    input  start, modo, fator, rom_data,
    output rom_addr, ram_wraddr, ram_data, ram_wren, busy, done, erro
  );

  modport slave (
    output start, modo, fator, rom_data,
    input  rom_addr, ram_wraddr, ram_data, ram_wren, busy, done, erro
  );
endinterface

// File: rtl/zoom_nn_ud.sv
// rtl/zoom_nn_ud.sv - nearest-neighbour zoom-in/zoom-out resampler, ROM to frame RAM
module zoom_nn_ud #(
  parameter int LARGURA = 160,
  parameter int ALTURA  = 120,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 19,
  parameter int FMAX    = 4,
  parameter int RD_LAT  = 1
) (
  input  logic           clk,
  input  logic           reset,
  zoom_nn_ud_if.master   bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_w, r_h, r_x, r_y, r_n;
  logic [ADDR_W-1:0] r_rstep, r_row_base, r_rom_addr;
  logic [2:0]        r_per, r_cstep, r_dj, r_di, r_dcnt;
  logic [RD_LAT-1:0] r_pv;
  logic [ADDR_W-1:0] r_pn [RD_LAT];
  logic [ADDR_W-1:0] r_ram_wraddr;
  logic [DATA_W-1:0] r_ram_data;
  logic              r_ram_wren, r_busy, r_done, r_erro;

  logic [ADDR_W-1:0] w_w, w_h, w_rstep;
  logic              w_legal;

  // Destination size per factor is an elaboration-time constant, so the
  // zoom-out division never reaches silicon as a divider.
  always_comb begin
    w_w     = '0;
    w_h     = '0;
    w_rstep = '0;
    for (int k = 1; k <= FMAX; k++) begin
      if (bus.fator == 3'(k)) begin
        if (bus.modo) begin
          w_w     = ADDR_W'(LARGURA / k);
          w_h     = ADDR_W'(ALTURA / k);
          w_rstep = ADDR_W'(LARGURA * k);
        end else begin
          w_w     = ADDR_W'(LARGURA * k);
          w_h     = ADDR_W'(ALTURA * k);
          w_rstep = ADDR_W'(LARGURA);
        end
      end
    end
    w_legal = (w_w != '0) && (w_h != '0);
  end

  // Zoom-in: source advances by 1 every f destination steps; zoom-out: by f every step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_w          <= '0;
      r_h          <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_n          <= '0;
      r_rstep      <= '0;
      r_row_base   <= '0;
      r_rom_addr   <= '0;
      r_per        <= '0;
      r_cstep      <= '0;
      r_dj         <= '0;
      r_di         <= '0;
      r_dcnt       <= '0;
      r_pv         <= '0;
      for (int k = 0; k < RD_LAT; k++) r_pn[k] <= '0;
      r_ram_wraddr <= '0;
      r_ram_data   <= '0;
      r_ram_wren   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_erro       <= 1'b0;
    end else begin
      for (int k = 1; k < RD_LAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pn[k] <= r_pn[k-1];
      end
      r_pv[0]    <= 1'b0;
      r_ram_wren <= r_pv[RD_LAT-1];
      if (r_pv[RD_LAT-1]) begin
        r_ram_wraddr <= r_pn[RD_LAT-1];
        r_ram_data   <= bus.rom_data;
      end
      r_erro <= 1'b0;
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_legal) begin
              r_w        <= w_w;
              r_h        <= w_h;
              r_rstep    <= w_rstep;
              r_per      <= bus.modo ? 3'd1 : bus.fator;
              r_cstep    <= bus.modo ? bus.fator : 3'd1;
              r_x        <= '0;
              r_y        <= '0;
              r_dj       <= '0;
              r_di       <= '0;
              r_n        <= '0;
              r_row_base <= '0;
              r_rom_addr <= '0;
              r_pv[0]    <= 1'b1;
              r_pn[0]    <= '0;
              r_busy     <= 1'b1;
              r_state    <= S_RUN;
            end else begin
              r_erro <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (r_x == r_w - ADDR_W'(1) && r_y == r_h - ADDR_W'(1)) begin
            r_dcnt  <= '0;
            r_state <= S_DRAIN;
          end else begin
            r_n     <= r_n + ADDR_W'(1);
            r_pv[0] <= 1'b1;
            r_pn[0] <= r_n + ADDR_W'(1);
            if (r_x == r_w - ADDR_W'(1)) begin
              r_x  <= '0;
              r_y  <= r_y + ADDR_W'(1);
              r_dj <= '0;
              if (r_di == r_per - 3'd1) begin
                r_di       <= '0;
                r_row_base <= r_row_base + r_rstep;
                r_rom_addr <= r_row_base + r_rstep;
              end else begin
                r_di       <= r_di + 3'd1;
                r_rom_addr <= r_row_base;
              end
            end else begin
              r_x <= r_x + ADDR_W'(1);
              if (r_dj == r_per - 3'd1) begin
                r_dj       <= '0;
                r_rom_addr <= r_rom_addr + ADDR_W'(r_cstep);
              end else begin
                r_dj <= r_dj + 3'd1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (r_dcnt == 3'(RD_LAT - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_dcnt <= r_dcnt + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr   = r_rom_addr;
  assign bus.ram_wraddr = r_ram_wraddr;
  assign bus.ram_data   = r_ram_data;
  assign bus.ram_wren   = r_ram_wren;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.erro       = r_erro;

endmodule

// File: tb/tb_zoom_nn_ud.sv
// tb/tb_zoom_nn_ud.sv - randomized bench for zoom_nn_ud against an arithmetic resampling model
module tb_zoom_nn_ud;
  localparam int LARGURA = 5;
  localparam int ALTURA  = 3;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 8;
  localparam int FMAX    = 4;
  localparam int RD_LAT  = 2;
  localparam int NSRC    = LARGURA * ALTURA;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  zoom_nn_ud_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  zoom_nn_ud #(
    .LARGURA(LARGURA), .ALTURA(ALTURA), .DATA_W(DATA_W),
    .ADDR_W(ADDR_W), .FMAX(FMAX), .RD_LAT(RD_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ROM with RD_LAT=2: the address sampled on one edge is read on the next.
  logic [DATA_W-1:0] rom [NSRC];
  logic [ADDR_W-1:0] r_hist;
  always @(posedge clk) r_hist <= bus.rom_addr;
  assign bus.rom_data = (int'(r_hist) < NSRC) ? rom[r_hist] : 8'hEE;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0, done_cnt = 0, erro_cnt = 0, oob_cnt = 0, busy_done = 0, done_cyc = 0;
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.ram_wren) begin
      wr_addr_q.push_back(int'(bus.ram_wraddr));
      wr_data_q.push_back(int'(bus.ram_data));
      wr_cyc_q.push_back(cyc + 1);
    end
    if (int'(bus.rom_addr) >= NSRC) oob_cnt <= oob_cnt + 1;
    if (bus.erro) erro_cnt <= erro_cnt + 1;
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc + 1;
      if (bus.busy) busy_done <= busy_done + 1;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic run_job(input int m, input int f, input bit restart);
    int w, h, legal, t0, guard, d0, e0, o0, b0, src, last;
    w = 0;
    h = 0;
    if (f >= 1 && f <= FMAX) begin
      w = (m != 0) ? LARGURA / f : LARGURA * f;
      h = (m != 0) ? ALTURA / f  : ALTURA * f;
    end
    legal = (w > 0 && h > 0) ? 1 : 0;
    for (int i = 0; i < NSRC; i++) rom[i] = DATA_W'($urandom);
    tick();
    clear_log();
    d0 = done_cnt; e0 = erro_cnt; o0 = oob_cnt; b0 = busy_done;
    bus.start = 1'b1;
    bus.modo  = m[0];
    bus.fator = f[2:0];
    t0 = cyc;
    tick();
    bus.start = 1'b0;
    bus.modo  = 1'($urandom);
    bus.fator = 3'($urandom);
    check_eq("busy_after_start", int'(bus.busy), legal);
    if (restart) begin
      repeat (6) tick();
      bus.start = 1'b1;
      bus.fator = 3'd3;
      tick();
      bus.start = 1'b0;
    end
    guard = 0;
    if (legal != 0) begin
      while (done_cnt == d0 && guard < 2000) begin
        tick();
        guard++;
      end
      if (guard >= 2000) check_eq("timeout_done", 0, 1);
    end
    repeat (4) tick();
    check_eq("idle_busy", int'(bus.busy), 0);
    check_eq("erro_pulses", erro_cnt - e0, 1 - legal);
    check_eq("done_pulses", done_cnt - d0, legal);
    check_eq("busy_with_done", busy_done - b0, 0);
    check_eq("rom_addr_range", oob_cnt - o0, 0);
    check_eq("write_count", wr_addr_q.size(), w * h);
    for (int i = 0; i < wr_addr_q.size() && i < w * h; i++) begin
      if (m != 0) src = (i / w) * f * LARGURA + (i % w) * f;
      else        src = ((i / w) / f) * LARGURA + (i % w) / f;
      check_eq("wr_addr", wr_addr_q[i], i);
      check_eq("wr_data", wr_data_q[i], int'(rom[src]));
    end
    if (legal != 0 && wr_addr_q.size() > 0) begin
      last = wr_cyc_q.size() - 1;
      check_eq("first_write_latency", wr_cyc_q[0] - t0, RD_LAT + 1);
      check_eq("stream_no_gaps", wr_cyc_q[last] - wr_cyc_q[0], last);
      check_eq("done_after_last", done_cyc - wr_cyc_q[last], 1);
    end
  endtask

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.modo  = 1'b0;
    bus.fator = 3'd0;
    for (int i = 0; i < NSRC; i++) rom[i] = DATA_W'(i);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.start = 1'($urandom);
      bus.modo  = 1'($urandom);
      bus.fator = 3'($urandom);
      check_eq("reset_outputs",
               int'({bus.rom_addr, bus.ram_wraddr, bus.ram_data, bus.ram_wren,
                     bus.busy, bus.done, bus.erro}), 0);
    end
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    run_job(0, 2, 1'b1);
    run_job(1, 2, 1'b0);
    run_job(1, 3, 1'b0);
    run_job(1, 4, 1'b0);
    run_job(0, 4, 1'b0);
    run_job(0, 1, 1'b0);
    run_job(1, 1, 1'b0);
    run_job(0, 3, 1'b0);
    run_job(0, 0, 1'b0);
    run_job(0, 5, 1'b0);
    run_job(1, 7, 1'b0);
    for (int j = 0; j < 8; j++) run_job(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'b0);

    // Abort a long zoom-in job with an asynchronous reset.
    tick();
    bus.start = 1'b1;
    bus.modo  = 1'b0;
    bus.fator = 3'd4;
    tick();
    bus.start = 1'b0;
    repeat (30) tick();
    reset = 1'b0;
    #1;
    check_eq("abort_wren", int'(bus.ram_wren), 0);
    check_eq("abort_busy", int'(bus.busy), 0);
    repeat (3) tick();
    clear_log();
    reset = 1'b1;
    repeat (300) tick();
    check_eq("writes_after_abort", wr_addr_q.size(), 0);
    check_eq("busy_after_abort", int'(bus.busy), 0);

    run_job(1, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/zoom_nn_ud.md
Name: zoom_nn_ud

Overview:
- Parametrised nearest-neighbour resampler for the coprocessor ULA. Zooms in by pixel replication or zooms out by decimation.
- Reads the source image from ROM and writes the destination image to the frame RAM in raster order, one pixel per clock.
- Adds a start/busy/done handshake, zoom-out mode, factor validation and configurable ROM read latency.
- Walks destination pixels with counters only: no multipliers or dividers in the address path.

Parameters:
- LARGURA, 160, source width in pixels.
- ALTURA, 120, source height in pixels.
- DATA_W, 8, pixel width in bits.
- ADDR_W, 19, ROM/RAM address width; must hold LARGURA*ALTURA*FMAX*FMAX-1.
- FMAX, 4, largest legal factor.
- RD_LAT, 1, ROM read latency in clocks (1..4).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- modo  in  1  0 = zoom-in (replicate), 1 = zoom-out (decimate); sampled with start.
- fator  in  3  scale factor; sampled with start.
- rom_addr  out  ADDR_W  source pixel address.
- rom_data  in  DATA_W  source pixel, valid RD_LAT clocks after rom_addr.
- ram_wraddr  out  ADDR_W  destination write address.
- ram_data  out  DATA_W  destination write data.
- ram_wren  out  1  destination write strobe.
- busy  out  1  high from the cycle after start is accepted until the last write has issued.
- done  out  1  one-cycle pulse after the last write.
- erro  out  1  one-cycle pulse when start carries an illegal factor.

Behaviour:
- Reset (async, active-low): every output is 0, FSM goes to IDLE, all counters and the latency pipe are cleared. Asserting reset mid-job aborts the job; no further writes occur after reset is released.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1, fator in 1..FMAX: latch modo and fator, compute destination size, go to RUN.
  - Zoom-in: W'=LARGURA*f, H'=ALTURA*f.
  - Zoom-out: W'=floor(LARGURA/f), H'=floor(ALTURA/f). Computed once, before the first address; an iterative divider is permitted.
  - If zoom-out gives W'=0 or H'=0, treat the request as illegal.
- IDLE, start=1, fator=0 or fator>FMAX: pulse erro for 1 cycle, stay in IDLE, no writes.
- RUN: one destination pixel (x',y') per clock, raster order, destination index n = y'*W'+x' counting 0..W'*H'-1.
  - Zoom-in: rom_addr = (y'/f)*LARGURA + (x'/f). Track with sub-counters di/dj so the source column advances every f destination pixels and the source row every f destination rows.
  - Zoom-out: rom_addr = (y'*f)*LARGURA + x'*f. Use stride accumulators; never multiply per pixel.
  - f=1: plain copy in either mode.
- Latency pipe: each rom_addr carries its n through an RD_LAT-deep valid/address shift register. On the RD_LAT-th edge after rom_addr is driven: ram_data <= rom_data, ram_wraddr <= n, ram_wren <= 1.
- Write stream: exactly W'*H' writes, strictly increasing ram_wraddr, no gaps once the stream starts, no duplicate addresses.
- RUN -> DRAIN after the last address is issued. DRAIN lasts RD_LAT cycles, then -> DONE.
- DONE: done=1 and busy=0 for one cycle, ram_wren=0, then -> IDLE.
- ram_wren is 0 in IDLE and DONE and whenever the pipe output is invalid.
- start is ignored while busy. modo and fator changes during a job have no effect.
- Address width: ram_wraddr never exceeds W'*H'-1. rom_addr never exceeds LARGURA*ALTURA-1.
- Zoom-out with non-divisible sizes drops the trailing source columns/rows.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0. Assert reset mid-RUN -> ram_wren=0 immediately and no writes after release.
- LARGURA=4, ALTURA=3, RD_LAT=1, modo=0, fator=2, ROM[i]=i -> 48 writes, addr 0..47. Row 0 data = 0,0,1,1,2,2,3,3; row 1 identical; row 2 starts 4,4. done pulses 1 cycle after write 47.
- Same size, modo=1, fator=2 -> W'=2, H'=1; exactly 2 writes: (0,0),(1,2). Source row 2 is dropped.
- Default 160x120, modo=0, fator=4, RD_LAT=3 -> 307200 contiguous writes. Last write addr 307199, data = ROM[19199]. First write 3 cycles after the first rom_addr.
- fator=0 and fator=5 with start -> erro pulses 1 cycle, busy stays 0, zero writes. fator=1 -> 19200 writes, an exact copy.
- start re-pulsed mid-job with fator=3 -> ignored; the job finishes with its original factor and the write count is unchanged.
